tlc_phase_ctrl: RTL

Parametrised N-phase traffic-light sequencer that replaces the fixed two-road main/country controller. It serves up to NUM_PHASES conflicting approaches round-robin. Phases with no pending vehicle or pedestrian demand are skipped. It supports peak-hour green lengths, a manual hold, and an offline flashing-yellow mode. It drives per-phase lamps and a seconds countdown that feeds the existing 7-segment display path.

---
 rtl/tlc_pkg.sv | 19 +
 rtl/tlc_tick_gen.sv | 22 ++
 rtl/tlc_phase_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types, limits and round-robin phase selection for the traffic-light sequencer.
package tlc_pkg;

  localparam int MAX_PHASES  = 8;
  localparam int MAX_SECONDS = 99;

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, FLASH} tlc_state_e;

  typedef logic [MAX_PHASES-1:0] lamp_t;

  // First pending phase after cur (cyclic over n phases); cur itself if none is pending.
  // Scanning from the farthest candidate down lets the nearest one overwrite the result.
  function automatic logic [2:0] next_phase(lamp_t pend, logic [2:0] cur, int n);
    next_phase = cur;
    for (int i = MAX_PHASES; i >= 1; i--)
      if (i <= n && pend[3'((int'(cur) + i) % n)]) next_phase = 3'((int'(cur) + i) % n);
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: 1 s tick prescaler.
//   clk, rst (async, active-low) ; en_i freezes the count when low ; clr_i restarts it at 0
//   tick_o: one-clk pulse on the last count of each TICK_DIV period
module tlc_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap;
  assign wrap   = cnt_q == CW'(TICK_DIV - 1);
  assign tick_o = en_i & ~clr_i & wrap;
  assign cnt_d  = clr_i ? '0 : !en_i ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/tlc_phase_ctrl.sv
// tlc_phase_ctrl: N-phase round-robin traffic-light sequencer with demand skipping.
//   clk, rst (async, active-low)
//   car_req/ped_req: per-phase demand levels ; peak: long green at next green entry
//   hold: freeze timing and lamps ; online=0: flashing-yellow mode
//   red/yellow/green/ped_walk: registered per-phase lamps
//   cur_phase: served phase ; countdown: seconds left in the current state
//   Build option TLC_PED_WALK_EN enables pedestrian demand and walk lamps.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES   = 2,
  parameter int TICK_DIV     = 50_000_000,
  parameter int GREEN_T      = 25,
  parameter int PEAK_GREEN_T = 40,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PHASES-1:0] car_req,
  input  logic [NUM_PHASES-1:0] ped_req,
  input  logic                  peak,
  input  logic                  hold,
  input  logic                  online,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] ped_walk,
  output logic [2:0]            cur_phase,
  output logic [6:0]            countdown
);
  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES ||
      GREEN_T < 1 || GREEN_T > MAX_SECONDS || PEAK_GREEN_T < 1 || PEAK_GREEN_T > MAX_SECONDS ||
      YELLOW_T < 1 || YELLOW_T > MAX_SECONDS || ALLRED_T < 1 || ALLRED_T > MAX_SECONDS) begin : g_bad_param
    $error("tlc_phase_ctrl: parameter out of range");
  end
  tlc_state_e state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [6:0] cnt_q, cnt_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d, ped_pend_q, ped_pend_d, ped_eff, sel;
  logic [NUM_PHASES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d, walk_q, walk_d;
  logic tick, mode_chg, green_entry;
`ifdef TLC_PED_WALK_EN
  assign ped_eff = ped_req;
`else
  assign ped_eff = ped_req & {NUM_PHASES{1'b0}};
`endif
  // Any flash entry/exit restarts the prescaler so flashing and the first ALLRED are full-length.
  assign mode_chg = online ^ (state_q != FLASH);
  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (~online | ~hold),
    .clr_i  (mode_chg),
    .tick_o (tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= ALLRED;
      phase_q    <= '0;
      cnt_q      <= 7'(ALLRED_T);
      pend_q     <= '0;
      ped_pend_q <= '0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
      walk_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ped_pend_q <= ped_pend_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      walk_q     <= walk_d;
    end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!online) begin
      state_d = FLASH;
      cnt_d   = '0;
    end else if (state_q == FLASH) begin
      state_d = ALLRED;
      phase_d = '0;
      cnt_d   = 7'(ALLRED_T);
    end else if (tick && cnt_q != 7'd1) begin
      cnt_d = cnt_q - 7'd1;
    end else if (tick) begin
      state_d = state_q == GREEN ? YELLOW : state_q == YELLOW ? ALLRED : GREEN;
      cnt_d   = state_q == GREEN ? 7'(YELLOW_T) : state_q == YELLOW ? 7'(ALLRED_T) :
                peak ? 7'(PEAK_GREEN_T) : 7'(GREEN_T);
      phase_d = state_q == ALLRED ? next_phase(lamp_t'(pend_q), phase_q, NUM_PHASES) : phase_q;
    end
  end
  always_comb begin
    sel         = {{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_d;
    green_entry = state_d == GREEN && state_q != GREEN;
    pend_d      = (pend_q | car_req | ped_eff) & ~(green_entry ? sel : '0);
    ped_pend_d  = (ped_pend_q | ped_eff) & ~(green_entry ? sel : '0);
    green_d     = state_d == GREEN ? sel : '0;
    yellow_d    = state_d == FLASH ? (state_q != FLASH ? '1 : tick ? ~yellow_q : yellow_q) :
                  state_d == YELLOW ? sel : '0;
    red_d       = state_d == FLASH ? '0 : ~(green_d | yellow_d);
    walk_d      = state_d != GREEN ? '0 : green_entry ? (|(ped_pend_q & sel) ? sel : '0) : walk_q;
  end
  assign red       = red_q;
  assign yellow    = yellow_q;
  assign green     = green_q;
  assign ped_walk  = walk_q;
  assign cur_phase = phase_q;
  assign countdown = cnt_q;
endmodule
